// File: rtl/dram_seq.sv
// DRAM access sequencer: tracks phi2, multiplexes row/column onto ba and drives RAS, per-bank CAS and W.
// Optional CAS-before-RAS refresh is built when DRAM_SEQ_REFRESH_EN is defined.
module dram_seq #(
    parameter int MA_W    = 8,
    parameter int NBANK   = 2,
    parameter int T_PRE   = 1,
    parameter int REF_DIV = 64,
    localparam int BW     = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              phi2,
    input  logic              rw,
    input  logic [2*MA_W-1:0] a,
    input  logic [BW-1:0]     bank,
    input  logic              extsel,
    input  logic              casinh,
    output logic              ras,
    output logic [NBANK-1:0]  cas,
    output logic              w,
    output logic [MA_W-1:0]   ba,
    output logic              busy,
    output logic              ref_act,
    output logic              ovr
);

    localparam int CW = $clog2(T_PRE + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_ROW, S_RAS, S_COL, S_CAS, S_PRE, S_R_CAS, S_R_RAS, S_R_PRE
    } state_t;

    state_t            state_q;
    logic              phi2_q;
    logic [2*MA_W-1:0] a_q, pa_q;
    logic              rw_q, prw_q;
    logic [BW-1:0]     bank_q, pbank_q;
    logic              cen_q, pcen_q;
    logic              acc_pend_q;
    logic [CW-1:0]     cnt_q;
    logic              ras_q, w_q, busy_q, ref_act_q, ovr_q;
    logic [NBANK-1:0]  cas_q;
    logic [MA_W-1:0]   ba_q;

    logic              st, fl, cen_in, ref_pend, ref_take;
    logic [2*MA_W-1:0] nxt_a;
    logic              nxt_rw, nxt_cen;
    logic [BW-1:0]     nxt_bank;
    logic [NBANK-1:0]  cas_on;

    assign st     = phi2 & ~phi2_q;
    assign fl     = ~phi2;
    assign cen_in = extsel & casinh;

    // A buffered request always wins over a fresh phi2 rise when leaving IDLE.
    assign nxt_a    = acc_pend_q ? pa_q    : a;
    assign nxt_rw   = acc_pend_q ? prw_q   : rw;
    assign nxt_bank = acc_pend_q ? pbank_q : bank;
    assign nxt_cen  = acc_pend_q ? pcen_q  : cen_in;

    assign ref_take = (state_q == S_IDLE) && ref_pend && !acc_pend_q && !st && !phi2;

    // NOTE: every variable in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cas_on = '1;
        for (int i = 0; i < NBANK; i++) begin
            if (cen_q && (bank_q == BW'(i))) cas_on[i] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phi2_q     <= 1'b0;
            a_q        <= '0;
            rw_q       <= 1'b1;
            bank_q     <= '0;
            cen_q      <= 1'b0;
            pa_q       <= '0;
            prw_q      <= 1'b1;
            pbank_q    <= '0;
            pcen_q     <= 1'b0;
            acc_pend_q <= 1'b0;
            cnt_q      <= '0;
            ras_q      <= 1'b1;
            cas_q      <= '1;
            w_q        <= 1'b1;
            ba_q       <= '0;
            busy_q     <= 1'b0;
            ref_act_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            phi2_q <= phi2;

            if (st && acc_pend_q) begin
                ovr_q <= 1'b1;
            end else if (st && (state_q != S_IDLE)) begin
                pa_q       <= a;
                prw_q      <= rw;
                pbank_q    <= bank;
                pcen_q     <= cen_in;
                acc_pend_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (acc_pend_q || st) begin
                        state_q    <= S_ROW;
                        a_q        <= nxt_a;
                        rw_q       <= nxt_rw;
                        bank_q     <= nxt_bank;
                        cen_q      <= nxt_cen;
                        ba_q       <= nxt_a[2*MA_W-1:MA_W];
                        busy_q     <= 1'b1;
                        acc_pend_q <= 1'b0;
                    end else if (ref_take) begin
                        state_q   <= S_R_CAS;
                        cas_q     <= '0;
                        busy_q    <= 1'b1;
                        ref_act_q <= 1'b1;
                    end
                end
                S_ROW: begin
                    state_q <= S_RAS;
                    ras_q   <= 1'b0;
                end
                S_RAS: begin
                    state_q <= S_COL;
                    ba_q    <= a_q[MA_W-1:0];
                    w_q     <= rw_q;
                end
                S_COL: begin
                    state_q <= S_CAS;
                    cas_q   <= cas_on;
                end
                S_CAS: begin
                    if (fl) begin
                        state_q <= S_PRE;
                        ras_q   <= 1'b1;
                        cas_q   <= '1;
                        w_q     <= 1'b1;
                        cnt_q   <= CW'(T_PRE - 1);
                    end
                end
                S_PRE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_R_CAS: begin
                    state_q <= S_R_RAS;
                    ras_q   <= 1'b0;
                    cnt_q   <= CW'(1);
                end
                S_R_RAS: begin
                    if (cnt_q == '0) begin
                        state_q <= S_R_PRE;
                        ras_q   <= 1'b1;
                        cas_q   <= '1;
                        cnt_q   <= CW'(T_PRE - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_R_PRE: begin
                    if (cnt_q == '0) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        ref_act_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DRAM_SEQ_REFRESH_EN
    localparam int RW = $clog2(REF_DIV);

    logic [RW-1:0] ref_cnt_q;
    logic          ref_pend_q;

    // A new expiry in the same cycle as a refresh start re-arms the request.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ref_cnt_q  <= RW'(REF_DIV - 1);
            ref_pend_q <= 1'b0;
        end else begin
            if (ref_take) ref_pend_q <= 1'b0;
            if (ref_cnt_q == '0) begin
                ref_cnt_q  <= RW'(REF_DIV - 1);
                ref_pend_q <= 1'b1;
            end else begin
                ref_cnt_q <= ref_cnt_q - RW'(1);
            end
        end
    end

    assign ref_pend = ref_pend_q;
    assign ref_act  = ref_act_q;
`else
    logic unused_refresh;

    assign ref_pend       = 1'b0;
    assign ref_act        = 1'b0;
    assign unused_refresh = ^{ref_act_q, 32'(REF_DIV)};
`endif

    assign ras  = ras_q;
    assign cas  = cas_q;
    assign w    = w_q;
    assign ba   = ba_q;
    assign busy = busy_q;
    assign ovr  = ovr_q;

endmodule

// File: doc/dram_seq.md
# dram_seq

Parametrised DRAM access sequencer, the next generation of the Freddie address-multiplexer/timing block. It tracks the CPU `phi2` clock, multiplexes the CPU address onto a row/column DRAM bus, and drives RAS, per-bank CAS and W.

It adds several things Freddie does not have:
- configurable address width and bank count
- fully registered, glitch-free strobes
- a one-deep pending-access buffer
- an overrun flag
- optional CAS-before-RAS refresh

It sits between the CPU bus and the DRAM array, in place of Freddie.

## Interface
Parameters:
- `MA_W`, 8: multiplexed DRAM address width; CPU address width is 2*MA_W.
- `NBANK`, 2: number of DRAM banks; one CAS line per bank; minimum 1.
- `T_PRE`, 1: precharge cycles after each access/refresh, ≥1.
- `REF_DIV`, 64: clk cycles between refresh requests, ≥8.

Ports:
- `clk_in` in 1: sequencer clock. Single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `phi2` in 1: CPU phase-2 clock, synchronous to `clk_in`.
- `rw` in 1: CPU read(1)/write(0).
- `a` in 2*MA_W: CPU address.
- `bank` in max(1,$clog2(NBANK)): bank select. A value ≥NBANK selects no bank.
- `extsel` in 1: active-low external select; low inhibits CAS.
- `casinh` in 1: active-low CAS inhibit.
- `ras` out 1: active-low RAS.
- `cas` out NBANK: active-low CAS, one line per bank.
- `w` out 1: active-low DRAM write enable.
- `ba` out MA_W: multiplexed row/column address.
- `busy` out 1: high in any state other than IDLE.
- `ref_act` out 1: high during refresh states.
- `ovr` out 1: sticky overrun flag; cleared only by reset.

## Operation
- Phase detection:
  - `phi2_q` registers `phi2` each cycle.
  - `st = phi2 & ~phi2_q` (rise).
  - `fl = ~phi2` (low).
- Access latch:
  - On `st`, capture `a`, `rw`, `bank` and `cen = extsel & casinh`.
  - In IDLE, the capture starts an access immediately.
  - Otherwise the capture sets `acc_pend`, provided `acc_pend` was 0.
  - If `st` occurs while `acc_pend`=1, the request is dropped and `ovr` is set.
- States: IDLE, ROW, RAS, COL, CAS, PRE, R_CAS, R_RAS, R_PRE.
- Transitions:
  - IDLE→ROW on `st` or `acc_pend`; `acc_pend` clears.
  - ROW→RAS.
  - RAS→COL.
  - COL→CAS.
  - CAS→PRE when `fl`, after at least 1 cycle in CAS.
  - PRE→IDLE after T_PRE cycles.
- Output decode (all outputs registered; values apply from the edge entering each state):
  - IDLE: ras=1, cas all 1, w=1, ba holds.
  - ROW: ba=row (`a_l[2*MA_W-1:MA_W]`), ras=1.
  - RAS: ras=0, ba=row.
  - COL: ba=column (`a_l[MA_W-1:0]`), ras=0; w=0 if the latched rw=0.
  - CAS: ras=0, ba=column, w as in COL. `cas[bank_l]`=0 only if cen=1 and bank_l<NBANK; all other CAS lines stay 1.
  - PRE: ras=1, cas all 1, w=1, ba holds column.
- With extsel or casinh low at `st`, the RAS-only cycle still runs and cas stays all 1.
- Arbitration: an access (`st` or `acc_pend`) has priority over refresh in IDLE.

## Timing
- Edge e0 is the edge at which `st`=1 with the sequencer in IDLE.
- Cycle timing from e0:
  - e0: ROW, ba=row.
  - e0+1: ras falls.
  - e0+2: ba=column; w falls for writes.
  - e0+3: cas falls.
  - cas rises at the first edge at which `phi2`=0 is seen while in CAS, but no earlier than e0+4.
  - IDLE is reached T_PRE edges after that.
- A pending access enters ROW on the edge after the sequencer reaches IDLE.
- Reset values:
  - ras=1, cas all 1, w=1, ba=0
  - busy=0, ref_act=0, ovr=0
  - acc_pend=0, ref_pend=0, phi2_q=0
  - state IDLE; refresh counter = REF_DIV-1
- Reset mid-operation forces all outputs to their reset values asynchronously. Latched and pending requests are lost.

## Configuration
- Macro: `DRAM_SEQ_REFRESH_EN`.
- Defined:
  - A down-counter reloads REF_DIV-1 on reaching 0 and sets `ref_pend`. A second expiry while `ref_pend` is still set is absorbed.
  - IDLE→R_CAS when `ref_pend`=1, `acc_pend`=0, `st`=0 and `phi2`=0; `ref_pend` clears.
  - R_CAS: cas all 0, ras=1, 1 cycle.
  - R_RAS: cas all 0, ras=0, 2 cycles.
  - R_PRE: all strobes 1, T_PRE cycles.
  - Then IDLE.
  - ref_act=1 in R_* states.
  - A `st` during refresh is buffered in `acc_pend` and executes after refresh completes.
  - cen is ignored during refresh.
- Undefined: no counter; refresh states are unreachable; ref_act is tied 0.

## Test plan
Configuration for all scenarios: MA_W=8, NBANK=2, T_PRE=1, REF_DIV=16.
- Reset: assert rst mid-CAS → ras=1, cas=2'b11, w=1, ba=8'h00, busy=0 without waiting for a clock edge.
- Read, a=16'h1234, bank=1, rw=1, phi2 high 6 cycles:
  - ba=8'h12 at e0..e0+1, ras=0 at e0+1.
  - ba=8'h34 at e0+2, cas=2'b01 at e0+3 until phi2 falls.
  - w=1 throughout; IDLE one cycle after cas rises.
- Write, a=16'hABCD, bank=0, rw=0: w=0 from e0+2 through the end of CAS, cas=2'b10, ba=8'hAB then 8'hCD.
- extsel=0 at `st`: ras pulses as in a read; cas stays 2'b11.
- Refresh (macro defined):
  - With phi2 low, 16 cycles after reset → ref_act=1, cas=2'b00, then ras=0 for 2 cycles.
  - A phi2 rise during R_RAS with a=16'h5A5A → access starts after IDLE with ba=8'h5A/8'h5A; ovr=0.
- Overrun: two phi2 rises while busy and acc_pend=1 → ovr=1 and stays 1. The first pending access completes normally.
